bus_mux_sync_tx: RTL and testbench



---
 rtl/bus_sync_pkg.sv | 14 +
 rtl/bus_sync_ack_ff.sv | 22 ++
 rtl/bus_mux_sync_tx.sv | 109 ++++++++++
 tb/tb_bus_mux_sync_tx.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sync_pkg.sv
// Shared definitions for the bus MUX synchronizer transmitter/receiver pair.
package bus_sync_pkg;

   localparam int unsigned DEFAULT_NUM_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      REQ     = 3'd2,
      RELEASE = 3'd3,
      GAP     = 3'd4
   } state_e;

endpackage

// File: rtl/bus_sync_ack_ff.sv
// Single-bit multi-flop synchronizer for the destination acknowledge.
module bus_sync_ack_ff
   import bus_sync_pkg::*;
#(
   parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [NUM_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) chain <= '0;
      else      chain <= {chain[NUM_STAGES-2:0], d};
   end

   assign q = chain[NUM_STAGES-1];

endmodule

// File: rtl/bus_mux_sync_tx.sv
// Source-side transmitter: holds a word on tx_bus and runs a 4-phase
// enable/ack handshake against the destination, with optional ack timeout.
module bus_mux_sync_tx
   import bus_sync_pkg::*;
#(
   parameter int unsigned BUS_WIDTH      = 8,
   parameter int unsigned NUM_STAGES     = DEFAULT_NUM_STAGES,
   parameter int unsigned GAP_CYCLES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] tx_bus,
   output logic                 tx_enable,
   input  logic                 ack_async,
   output logic                 done,
   output logic                 err,
   input  logic                 clr_err
);

   localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST  =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit TO_ENABLE = (TIMEOUT_CYCLES != 0);

   state_e               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic                 ack_sync;
   logic                 armed;

   bus_sync_ack_ff #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ack_ff (
      .clk (clk),
      .rst (rst),
      .d   (ack_async),
      .q   (ack_sync)
   );

   // Saturating increment so a long wait never wraps back into a match.
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);

   // armed keeps in_ready low until the first edge after reset release.
   assign in_ready = armed && (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         tx_bus    <= '0;
         tx_enable <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         armed     <= 1'b0;
      end else begin
         armed <= 1'b1;
         done  <= 1'b0;
         // A timeout set below overrides a same-cycle clear.
         if (clr_err) err <= 1'b0;

         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  tx_bus <= in_data;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               tx_enable <= 1'b1;
               cnt       <= '0;
               state     <= REQ;
            end
            REQ: begin
               cnt <= cnt_inc;
               if (ack_sync) begin
                  tx_enable <= 1'b0;
                  state     <= RELEASE;
               end else if (TO_ENABLE && (cnt == TO_LAST)) begin
                  err       <= 1'b1;
                  tx_enable <= 1'b0;
                  cnt       <= '0;
                  state     <= GAP;
               end
            end
            RELEASE: begin
               if (!ack_sync) begin
                  done  <= 1'b1;
                  cnt   <= '0;
                  state <= GAP;
               end
            end
            GAP: begin
               cnt <= cnt_inc;
               if (cnt == GAP_LAST) state <= IDLE;
            end
            default: begin
               tx_enable <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_mux_sync_tx.sv
// Self-checking bench for bus_mux_sync_tx: scenario tasks plus a done-pulse scoreboard.
module tb_bus_mux_sync_tx;

   localparam int unsigned BW    = 8;
   localparam int unsigned NS    = 2;
   localparam int unsigned GAP   = 2;
   localparam int unsigned TO    = 10;
   localparam int unsigned ACK_D = 3;

   logic          clk, rst;
   logic [BW-1:0] in_data;
   logic          in_valid, in_ready;
   logic [BW-1:0] tx_bus;
   logic          tx_enable, ack_async, done, err, clr_err;

   int            vec_cnt = 0;
   int            err_cnt = 0;
   int            done_cnt = 0;
   logic [BW-1:0] exp_q[$];
   logic          resp_on = 1'b0;
   logic          prev_done = 1'b0;

   bus_mux_sync_tx #(
      .BUS_WIDTH      (BW),
      .NUM_STAGES     (NS),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TO),
      .CNT_WIDTH      (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .tx_bus    (tx_bus),
      .tx_enable (tx_enable),
      .ack_async (ack_async),
      .done      (done),
      .err       (err),
      .clr_err   (clr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Destination model: ack follows enable after ACK_D cycles, each way.
   initial begin
      int r_cnt;
      r_cnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!resp_on) r_cnt = 0;
         else if (tx_enable && !ack_async) begin
            r_cnt++;
            if (r_cnt == ACK_D) begin ack_async = 1'b1; r_cnt = 0; end
         end else if (!tx_enable && ack_async) begin
            r_cnt++;
            if (r_cnt == ACK_D) begin ack_async = 1'b0; r_cnt = 0; end
         end else r_cnt = 0;
      end
   end

   // Scoreboard: every done pulse pops the word that was accepted for it.
   always @(negedge clk) begin
      if (rst && done) begin
         done_cnt++;
         vec_cnt++;
         if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL sb_unexpected_done: tx_bus=%h with no word pending", tx_bus);
         end else begin
            logic [BW-1:0] e;
            e = exp_q.pop_front();
            if (tx_bus !== e) begin
               err_cnt++;
               $display("FAIL sb_bus_at_done: got %h expected %h", tx_bus, e);
            end
         end
         if (prev_done) begin
            err_cnt++;
            $display("FAIL done_width: done high two cycles in a row, got 1 expected 0");
         end
      end
      prev_done = done;
   end

   task automatic test_reset();
      rst = 1'b0; in_data = '0; in_valid = 1'b0; ack_async = 1'b0; clr_err = 1'b0;
      repeat (3) tick();
      vec_cnt++;
      if ({tx_bus, tx_enable, in_ready, done, err} !== {8'h00, 4'b0000}) begin
         err_cnt++;
         $display("FAIL reset_outputs: bus=%h en=%b rdy=%b done=%b err=%b expected all 0",
                  tx_bus, tx_enable, in_ready, done, err);
      end
      rst = 1'b1;
      tick();
      vec_cnt++;
      if (in_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int n;
      resp_on = 1'b1;
      in_data = 8'hA5; in_valid = 1'b1;
      exp_q.push_back(8'hA5);
      tick();
      in_valid = 1'b0;
      vec_cnt++;
      if (tx_bus !== 8'hA5 || tx_enable !== 1'b0 || in_ready !== 1'b0) begin
         err_cnt++;
         $display("FAIL basic_e0: bus=%h en=%b rdy=%b expected a5 0 0", tx_bus, tx_enable, in_ready);
      end
      tick();
      vec_cnt++;
      if (tx_enable !== 1'b1) begin
         err_cnt++;
         $display("FAIL basic_en_rise: tx_enable=%b expected 1", tx_enable);
      end
      n = 0;
      while (tx_enable === 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (n != ACK_D + NS) begin
         err_cnt++;
         $display("FAIL basic_en_width: %0d cycles expected %0d", n, ACK_D + NS);
      end
      n = 0;
      while (done !== 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (n != ACK_D + NS) begin
         err_cnt++;
         $display("FAIL basic_release_to_done: %0d cycles expected %0d", n, ACK_D + NS);
      end
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (n != GAP || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL basic_gap: %0d cycles err=%b expected %0d err=0", n, err, GAP);
      end
   endtask

   task automatic test_back_to_back();
      int start_done, accepted, n;
      logic [BW-1:0] cur;
      logic acc_now;
      resp_on = 1'b1;
      start_done = done_cnt;
      accepted = 0; n = 0; cur = '0;
      in_data = 8'h01; in_valid = 1'b1;
      while (done_cnt - start_done < 2 && n < 200) begin
         acc_now = in_valid && in_ready;
         if (acc_now) begin exp_q.push_back(in_data); cur = in_data; end
         tick();
         n++;
         if (acc_now) begin
            accepted++;
            if (accepted == 1) in_data = 8'h02; else in_valid = 1'b0;
         end
         vec_cnt++;
         if (tx_bus !== cur) begin
            err_cnt++;
            $display("FAIL b2b_bus_stable: cycle %0d bus=%h expected %h", n, tx_bus, cur);
         end
      end
      in_valid = 1'b0;
      vec_cnt++;
      if (done_cnt - start_done != 2 || accepted != 2) begin
         err_cnt++;
         $display("FAIL b2b_count: done=%0d accepted=%0d expected 2 2",
                  done_cnt - start_done, accepted);
      end
      while (in_ready !== 1'b1 && n < 260) begin tick(); n++; end
   endtask

   task automatic test_timeout();
      int n, start_done;
      resp_on = 1'b0; ack_async = 1'b0;
      start_done = done_cnt;
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      n = 0;
      while (tx_enable === 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (n != TO || err !== 1'b1) begin
         err_cnt++;
         $display("FAIL timeout_width: en %0d cycles err=%b expected %0d err=1", n, err, TO);
      end
      repeat (GAP) tick();
      vec_cnt++;
      if (in_ready !== 1'b1 || done_cnt != start_done || err !== 1'b1) begin
         err_cnt++;
         $display("FAIL timeout_after: rdy=%b dones=%0d err=%b expected 1 0 1",
                  in_ready, done_cnt - start_done, err);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      vec_cnt++;
      if (err !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_clr: err=%b expected 0", err);
      end
      resp_on = 1'b1;
      in_data = 8'h5A; in_valid = 1'b1;
      exp_q.push_back(8'h5A);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (done !== 1'b1 || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL timeout_next_xfer: done=%b err=%b expected 1 0", done, err);
      end
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
   endtask

   task automatic test_coincide();
      int n;
      resp_on = 1'b0; ack_async = 1'b0;
      in_data = 8'h96; in_valid = 1'b1;
      exp_q.push_back(8'h96);
      tick();
      in_valid = 1'b0;
      tick();
      // ack_sync must be high just before the edge where the 10th REQ cycle ends
      repeat (TO - NS - 1) tick();
      ack_async = 1'b1;
      repeat (NS) tick();
      vec_cnt++;
      if (tx_enable !== 1'b1) begin
         err_cnt++;
         $display("FAIL coincide_pre: tx_enable=%b expected 1", tx_enable);
      end
      tick();
      vec_cnt++;
      if (tx_enable !== 1'b0 || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL coincide_edge: en=%b err=%b expected 0 0", tx_enable, err);
      end
      ack_async = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (done !== 1'b1 || err !== 1'b0) begin
         err_cnt++;
         $display("FAIL coincide_done: done=%b err=%b expected 1 0", done, err);
      end
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
   endtask

   task automatic test_reset_mid();
      int start_done;
      resp_on = 1'b0; ack_async = 1'b0;
      start_done = done_cnt;
      in_data = 8'hE7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      vec_cnt++;
      if (tx_enable !== 1'b1 || tx_bus !== 8'hE7) begin
         err_cnt++;
         $display("FAIL rstmid_pre: en=%b bus=%h expected 1 e7", tx_enable, tx_bus);
      end
      rst = 1'b0;
      #1;
      vec_cnt++;
      if ({tx_bus, tx_enable, done, in_ready} !== {8'h00, 3'b000}) begin
         err_cnt++;
         $display("FAIL rstmid_async: bus=%h en=%b done=%b rdy=%b expected 00 0 0 0",
                  tx_bus, tx_enable, done, in_ready);
      end
      rst = 1'b1;
      tick();
      vec_cnt++;
      if (in_ready !== 1'b1) begin
         err_cnt++;
         $display("FAIL rstmid_ready: in_ready=%b expected 1", in_ready);
      end
      repeat (4) tick();
      vec_cnt++;
      if (done_cnt != start_done) begin
         err_cnt++;
         $display("FAIL rstmid_nodone: %0d done pulses expected 0", done_cnt - start_done);
      end
   endtask

   task automatic test_stale_ack();
      int n;
      resp_on = 1'b0;
      ack_async = 1'b1;
      repeat (NS + 1) tick();
      in_data = 8'hC3; in_valid = 1'b1;
      exp_q.push_back(8'hC3);
      tick();
      in_valid = 1'b0;
      tick();
      vec_cnt++;
      if (tx_enable !== 1'b1) begin
         err_cnt++;
         $display("FAIL stale_en_rise: tx_enable=%b expected 1", tx_enable);
      end
      tick();
      vec_cnt++;
      if (tx_enable !== 1'b0) begin
         err_cnt++;
         $display("FAIL stale_req_len: tx_enable=%b after 1 REQ cycle expected 0", tx_enable);
      end
      repeat (4) tick();
      vec_cnt++;
      if (done !== 1'b0 || in_ready !== 1'b0 || tx_bus !== 8'hC3) begin
         err_cnt++;
         $display("FAIL stale_hold: done=%b rdy=%b bus=%h expected 0 0 c3", done, in_ready, tx_bus);
      end
      ack_async = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 50) begin tick(); n++; end
      vec_cnt++;
      if (n != NS + 1) begin
         err_cnt++;
         $display("FAIL stale_done: %0d cycles to done expected %0d", n, NS + 1);
      end
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_timeout();
      test_coincide();
      test_reset_mid();
      test_stale_ack();
      repeat (2) tick();
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL sb_leftover: %0d words pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
